// File: rtl/regfile_index_encoder.sv
// Sequential 32-to-5 encoder: walks a register mask and emits one set-bit index
// per handshake, lowest-first or highest-first, with count/last/done status.
module regfile_index_encoder #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        flush,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic [5:0]  count,
    output logic        busy,
    output logic        done
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    logic        state;
    logic [31:0] pending;
    logic [4:0]  sel_index;
    logic [5:0]  pop;
    logic        load_take;

    // NOTE: every always_comb output gets a default before the loop, otherwise
    // an empty pending mask would leave sel_index unassigned and infer a latch.
    always_comb begin
        sel_index = '0;
        if (LSB_FIRST) begin
            for (int i = 31; i >= 0; i--)
                if (pending[i]) sel_index = 5'(i);
        end else begin
            for (int i = 0; i < 32; i++)
                if (pending[i]) sel_index = 5'(i);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++)
            pop = pop + 6'(pending[i]);
    end

    assign out_valid  = (state == ST_DRAIN);
    assign busy       = out_valid;
    assign load_ready = (state == ST_IDLE) && !flush;
    assign load_take  = load_valid && load_ready;
    assign out_index  = out_valid ? sel_index : 5'd0;
    assign count      = out_valid ? pop : 6'd0;
    assign out_last   = out_valid && (pop == 6'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state   <= ST_IDLE;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // An in-flight handshake still counts as consumed; nothing follows it.
                state   <= ST_IDLE;
                pending <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_take) begin
                            if (load_mask != 32'd0) begin
                                pending <= load_mask;
                                state   <= ST_DRAIN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_ready) begin
                            pending <= pending & ~(32'd1 << sel_index);
                            if (out_last) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_index_encoder.sv
// Bench for regfile_index_encoder: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against queue-based reference models.
module tb_regfile_index_encoder;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        flush;
    logic        load_valid;
    logic [31:0] load_mask;
    logic        out_ready;

    logic       l_load_ready, l_valid, l_last, l_busy, l_done;
    logic [4:0] l_index;
    logic [5:0] l_count;
    logic       m_load_ready, m_valid, m_last, m_busy, m_done;
    logic [4:0] m_index;
    logic [5:0] m_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: the indices still to be emitted, in emission order.
    int q_l[$];
    int q_m[$];
    bit done_l, done_m;

    always #5 clock = ~clock;

    regfile_index_encoder #(.LSB_FIRST(1'b1)) dut_l (
        .clock(clock), .ctrl_reset(ctrl_reset), .flush(flush),
        .load_valid(load_valid), .load_ready(l_load_ready), .load_mask(load_mask),
        .out_valid(l_valid), .out_ready(out_ready), .out_index(l_index),
        .out_last(l_last), .count(l_count), .busy(l_busy), .done(l_done)
    );

    regfile_index_encoder #(.LSB_FIRST(1'b0)) dut_m (
        .clock(clock), .ctrl_reset(ctrl_reset), .flush(flush),
        .load_valid(load_valid), .load_ready(m_load_ready), .load_mask(load_mask),
        .out_valid(m_valid), .out_ready(out_ready), .out_index(m_index),
        .out_last(m_last), .count(m_count), .busy(m_busy), .done(m_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed {valid, index, last, count, busy, done, load_ready}.
    function automatic logic [31:0] expect_of(input int n, input int front, input bit d);
        logic v;
        v = (n > 0);
        return {16'd0, v, (v ? 5'(front) : 5'd0), (n == 1), 6'(n), v, d, (n == 0) && !flush};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_lsb"}, {16'd0, l_valid, l_index, l_last, l_count, l_busy, l_done, l_load_ready},
              expect_of(q_l.size(), (q_l.size() > 0) ? q_l[0] : 0, done_l));
        check({tag, "_msb"}, {16'd0, m_valid, m_index, m_last, m_count, m_busy, m_done, m_load_ready},
              expect_of(q_m.size(), (q_m.size() > 0) ? q_m[0] : 0, done_m));
    endtask

    task automatic model_reset();
        q_l.delete();
        q_m.delete();
        done_l = 1'b0;
        done_m = 1'b0;
    endtask

    task automatic model_edge();
        bit nd;
        nd = 1'b0;
        if (!ctrl_reset) begin
            model_reset();
            return;
        end
        if (flush) begin
            q_l.delete();
            q_m.delete();
        end else if (q_l.size() == 0) begin
            if (load_valid) begin
                if (load_mask == 32'd0) nd = 1'b1;
                for (int i = 0; i < 32; i++)
                    if (load_mask[i]) begin
                        q_l.push_back(i);
                        q_m.push_front(i);
                    end
            end
        end else if (out_ready) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
            if (q_l.size() == 0) nd = 1'b1;
        end
        done_l = nd;
        done_m = nd;
    endtask

    // Check at the falling edge, update the model at the rising edge, return 1 unit later.
    task automatic cycle();
        @(negedge clock);
        check_outputs("cyc");
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic load(input logic [31:0] mask);
        load_valid = 1'b1;
        load_mask  = mask;
        cycle();
        load_valid = 1'b0;
        load_mask  = $urandom;
    endtask

    initial begin
        int dones;
        int r;
        model_reset();
        ctrl_reset = 1'b0;
        flush      = 1'b0;
        load_valid = 1'b1;
        load_mask  = 32'h5;
        out_ready  = 1'b1;

        // 1: reset with a pending load request, then a two-bit mask.
        #3;
        check_outputs("p1_reset");
        cycle();
        cycle();
        ctrl_reset = 1'b1;
        load(32'h0000_0005);
        check("p1_idx0", l_index, 0);
        check("p1_cnt2", l_count, 2);
        cycle();
        check("p1_idx2", {l_index, l_last}, {5'd2, 1'b1});
        cycle();
        check("p1_done", l_done, 1);
        cycle();

        // 2: highest-first ordering.
        load(32'h8000_0011);
        check("p2_m31", {m_index, m_count}, {5'd31, 6'd3});
        cycle();
        check("p2_m4", {m_index, m_count}, {5'd4, 6'd2});
        cycle();
        check("p2_m0", {m_index, m_count, m_last}, {5'd0, 6'd1, 1'b1});
        cycle();
        check("p2_done", m_done, 1);
        cycle();

        // 3: full mask with a stalling consumer.
        load(32'hFFFF_FFFF);
        check("p3_cnt32", {l_count, m_count}, {6'd32, 6'd32});
        dones = 0;
        for (int c = 0; c < 70; c++) begin
            out_ready = (c % 2 == 0);
            cycle();
            if (l_done) dones++;
        end
        check("p3_done_count", dones, 1);
        out_ready = 1'b1;

        // Bit 31 only: index 31 and last in both orderings.
        load(32'h8000_0000);
        check("b31_lsb", {l_index, l_last}, {5'd31, 1'b1});
        check("b31_msb", {m_index, m_last}, {5'd31, 1'b1});
        cycle();
        cycle();

        // 4: empty mask.
        load(32'h0);
        check("p4_novalid", {l_valid, l_done, l_load_ready}, 3'b011);
        cycle();
        check("p4_done_gone", l_done, 0);

        // 5: flush after the first handshake.
        load(32'h0000_00F0);
        check("p5_idx4", l_index, 4);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("p5_flushed", {l_busy, l_count, l_done}, {1'b0, 6'd0, 1'b0});
        cycle();
        load(32'h2);
        check("p5_idx1", {l_index, m_index}, {5'd1, 5'd1});
        cycle();
        cycle();

        // 6: asynchronous reset between edges mid-drain.
        load(32'h0000_0F00);
        cycle();
        #2;
        ctrl_reset = 1'b0;
        model_reset();
        #1;
        check_outputs("p6_async");
        check("p6_valid", {l_valid, m_valid, l_count}, 8'd0);
        cycle();
        ctrl_reset = 1'b1;
        load(32'h0000_0400);
        check("p6_idx10", {l_index, l_last, m_index, m_last}, {5'd10, 1'b1, 5'd10, 1'b1});
        cycle();
        cycle();

        // Randomized traffic, including mask changes outside accept edges.
        for (int c = 0; c < 3000; c++) begin
            flush      = ($urandom_range(0, 19) == 0);
            load_valid = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 3);
            case (r)
                0: load_mask = 32'h0;
                1: load_mask = 32'd1 << $urandom_range(0, 31);
                2: load_mask = $urandom & $urandom & $urandom;
                default: load_mask = $urandom;
            endcase
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
